regfile_wb_arbiter: RTL and testbench

- Write-port arbiter/scheduler in front of the 32x32 register file, which has a single write port.
- Merges two writeback sources: ALU results, including JAL link writes to r31, and memory load returns.
- Buffers ALU writes in a small FIFO so loads never stall.
- Drives the regfile write port from registered outputs and flags read hazards against writes not yet committed.

---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 66 ++++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter: special register
// addresses, the writeback request record and the ALU destination helper.
package regfile_wb_arbiter_pkg;

  localparam logic [4:0] REG_LINK = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         WB_W     = 32;

  typedef struct packed {
    logic            valid;
    logic [4:0]      wr;
    logic [WB_W-1:0] data;
  } wb_req_t;

  // Link writes always target r31 regardless of the encoded destination.
  function automatic logic [4:0] alu_dest(input logic jal, input logic [4:0] wr);
    return jal ? REG_LINK : wr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small pending-write FIFO for ALU results. Head is read combinationally so a
// pop can issue in the same cycle; every slot's destination is exposed for hazards.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [4:0]             push_wr,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [4:0]             head_wr,
  output logic [W-1:0]           head_data,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH*5-1:0]     entry_wr
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]   wr_mem   [DEPTH];
  logic [W-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PW:0]   count_reg;

  // Slot contents need no reset: they are only observed while marked valid.
  always_ff @(posedge clock) begin
    if (push) begin
      wr_mem[wr_ptr_reg]   <= push_wr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign head_wr   = wr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset                 = PW'(gi) - rd_ptr_reg;
      assign entry_valid[gi]        = ({1'b0, offset} < count_reg);
      assign entry_wr[gi*5 +: 5]    = wr_mem[gi];
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single-write-port scheduler for the register file: loads win, ALU results
// bypass or queue, the chosen write is registered, and pending writes flag read hazards.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_wr,
  input  logic            alu_jal,
  input  logic [W-1:0]    alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_wr,
  input  logic [W-1:0]    mem_data,
  input  logic [4:0]      rr1_in,
  input  logic [4:0]      rr2_in,
  output logic            hazard1,
  output logic            hazard2,
  output logic            regwrite,
  output logic [4:0]      wr_out,
  output logic [W-1:0]    write_data_out,
  output logic [CNTW-1:0] stall_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]        fifo_count;
  logic [4:0]         head_wr;
  logic [W-1:0]       head_data;
  logic [DEPTH-1:0]   entry_valid;
  logic [DEPTH*5-1:0] entry_wr;

  logic [4:0] alu_eff_wr;
  logic       fifo_empty, alu_live, mem_live, bypass_sel;
  logic       push_next, pop_next;
  wb_req_t    sel_next;

  logic            regwrite_reg;
  logic [4:0]      wr_out_reg;
  logic [W-1:0]    write_data_reg;
  logic [CNTW-1:0] stall_count_reg;

  assign alu_eff_wr = alu_dest(alu_jal, alu_wr);
  assign fifo_empty = (fifo_count == '0);
  assign alu_ready  = (fifo_count < (PW+1)'(DEPTH));
  // r0 requests complete the handshake but never reach the write port.
  assign alu_live   = alu_valid && alu_ready && (alu_eff_wr != REG_ZERO);
  assign mem_live   = mem_valid && (mem_wr != REG_ZERO);
  assign bypass_sel = !mem_live && fifo_empty && alu_live;
  assign pop_next   = !mem_live && !fifo_empty;
  assign push_next  = alu_live && !bypass_sel;

  always_comb begin
    sel_next = '0;
    if (mem_live) begin
      sel_next.valid = 1'b1;
      sel_next.wr    = mem_wr;
      sel_next.data  = WB_W'(mem_data);
    end else if (!fifo_empty) begin
      sel_next.valid = 1'b1;
      sel_next.wr    = head_wr;
      sel_next.data  = WB_W'(head_data);
    end else if (alu_live) begin
      sel_next.valid = 1'b1;
      sel_next.wr    = alu_eff_wr;
      sel_next.data  = WB_W'(alu_data);
    end
  end

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push_next),
    .push_wr     (alu_eff_wr),
    .push_data   (alu_data),
    .pop         (pop_next),
    .count       (fifo_count),
    .head_wr     (head_wr),
    .head_data   (head_data),
    .entry_valid (entry_valid),
    .entry_wr    (entry_wr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite_reg    <= 1'b0;
      wr_out_reg      <= '0;
      write_data_reg  <= '0;
      stall_count_reg <= '0;
    end else begin
      regwrite_reg <= sel_next.valid;
      if (sel_next.valid) begin
        wr_out_reg     <= sel_next.wr;
        write_data_reg <= W'(sel_next.data);
      end
      if (alu_valid && !alu_ready && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign regwrite       = regwrite_reg;
  assign wr_out         = wr_out_reg;
  assign write_data_out = write_data_reg;
  assign stall_count    = stall_count_reg;

  // Output stage counts as pending: the regfile only sees it after this cycle.
  logic [DEPTH-1:0] fifo_hit1, fifo_hit2;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      assign fifo_hit1[gi] = entry_valid[gi] && (entry_wr[gi*5 +: 5] == rr1_in);
      assign fifo_hit2[gi] = entry_valid[gi] && (entry_wr[gi*5 +: 5] == rr2_in);
    end
  endgenerate

  assign hazard1 = (rr1_in != REG_ZERO) &&
                   ((|fifo_hit1) || (regwrite_reg && (wr_out_reg == rr1_in)));
  assign hazard2 = (rr2_in != REG_ZERO) &&
                   ((|fifo_hit2) || (regwrite_reg && (wr_out_reg == rr2_in)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a default instance plus a CNTW=4
// instance sharing the same stimulus for the counter saturation case.
module tb_regfile_wb_arbiter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         alu_valid, alu_jal, mem_valid;
  logic [4:0]   alu_wr, mem_wr, rr1_in, rr2_in;
  logic [W-1:0] alu_data, mem_data;

  logic         alu_ready, hazard1, hazard2, regwrite;
  logic [4:0]   wr_out;
  logic [W-1:0] write_data_out;
  logic [15:0]  stall_count;

  logic         s_alu_ready, s_hazard1, s_hazard2, s_regwrite;
  logic [4:0]   s_wr_out;
  logic [W-1:0] s_write_data_out;
  logic [3:0]   s_stall_count;

  int tests_run    = 0;
  int tests_failed = 0;

  regfile_wb_arbiter #(.W(W), .DEPTH(2), .CNTW(16)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_wr(alu_wr), .alu_jal(alu_jal), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_data(mem_data),
    .rr1_in(rr1_in), .rr2_in(rr2_in), .hazard1(hazard1), .hazard2(hazard2),
    .regwrite(regwrite), .wr_out(wr_out), .write_data_out(write_data_out),
    .stall_count(stall_count)
  );

  regfile_wb_arbiter #(.W(W), .DEPTH(2), .CNTW(4)) dut_sat (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_wr(alu_wr), .alu_jal(alu_jal), .alu_data(alu_data),
    .alu_ready(s_alu_ready),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_data(mem_data),
    .rr1_in(rr1_in), .rr2_in(rr2_in), .hazard1(s_hazard1), .hazard2(s_hazard2),
    .regwrite(s_regwrite), .wr_out(s_wr_out), .write_data_out(s_write_data_out),
    .stall_count(s_stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] wr,
                          input logic [31:0] data);
    check({tag, ".regwrite"}, regwrite, we);
    check({tag, ".wr_out"}, wr_out, wr);
    check({tag, ".data"}, write_data_out, data);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_jal = 1'b0; alu_wr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_wr = '0; mem_data = '0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] exp_wr   [7];
    logic [31:0] exp_data [7];
    logic        exp_rdy  [6];
    int          idx;
    logic        acc;

    idle();
    rr1_in = '0; rr2_in = '0;
    #1 reset = 1'b0;
    #1;
    check("reset.regwrite", regwrite, 0);
    check("reset.wr_out", wr_out, 0);
    check("reset.data", write_data_out, 0);
    check("reset.stall", stall_count, 0);
    check("reset.hazard1", hazard1, 0);
    check("reset.ready", alu_ready, 1);
    tick(); tick();
    #2 reset = 1'b1;
    tick();

    // ALU-only direct path
    alu_valid = 1'b1; alu_wr = 5'd5; alu_data = 32'hA5; rr1_in = 5'd5;
    #1;
    check("direct.ready", alu_ready, 1);
    check("direct.haz_req_ignored", hazard1, 0);
    tick();
    idle();
    check_wb("direct", 1'b1, 5'd5, 32'hA5);
    check("direct.haz_outstage", hazard1, 1);
    tick();
    check_wb("direct.idle", 1'b0, 5'd5, 32'hA5);
    check("direct.haz_cleared", hazard1, 0);

    // Load priority with ALU buffered behind it
    rr1_in = 5'd9;
    mem_valid = 1'b1; mem_wr = 5'd8; mem_data = 32'h11;
    alu_valid = 1'b1; alu_wr = 5'd9; alu_data = 32'h22;
    #1;
    check("prio.haz_pre", hazard1, 0);
    tick();
    idle();
    check_wb("prio.c1", 1'b1, 5'd8, 32'h11);
    check("prio.haz_c1", hazard1, 1);
    tick();
    check_wb("prio.c2", 1'b1, 5'd9, 32'h22);
    check("prio.haz_c2", hazard1, 1);
    tick();
    check("prio.c3.regwrite", regwrite, 0);
    check("prio.haz_c3", hazard1, 0);
    rr1_in = '0;

    // FIFO full stall while loads hold the port
    exp_wr   = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd1, 32'd2, 32'd3};
    exp_data = '{32'h110, 32'h111, 32'h112, 32'h113, 32'h201, 32'h202, 32'h203};
    exp_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      mem_valid = (c < 4);
      mem_wr    = 5'(10 + c);
      mem_data  = 32'h110 + 32'(c);
      alu_valid = (idx < 3);
      alu_wr    = 5'(idx + 1);
      alu_data  = 32'h201 + 32'(idx);
      #1;
      if (c < 6) check($sformatf("full.ready_c%0d", c), alu_ready, exp_rdy[c]);
      acc = alu_valid && alu_ready;
      tick();
      if (acc) idx++;
      check_wb($sformatf("full.c%0d", c), 1'b1, exp_wr[c][4:0], exp_data[c]);
      if (c == 3) check("full.stall_at_load_end", stall_count, 2);
    end
    idle();
    check("full.stall_final", stall_count, 3);
    tick();
    check("full.drained.regwrite", regwrite, 0);

    // JAL link write and r0 discards
    alu_valid = 1'b1; alu_jal = 1'b1; alu_wr = 5'd0; alu_data = 32'h400;
    tick();
    idle();
    check_wb("jal", 1'b1, 5'd31, 32'h400);
    alu_valid = 1'b1; alu_wr = 5'd0; alu_data = 32'h55;
    #1;
    check("r0alu.ready", alu_ready, 1);
    tick();
    idle();
    check_wb("r0alu", 1'b0, 5'd31, 32'h400);
    mem_valid = 1'b1; mem_wr = 5'd0; mem_data = 32'h66;
    tick();
    idle();
    check_wb("r0mem", 1'b0, 5'd31, 32'h400);

    // Asynchronous reset with two buffered writes
    rr1_in = 5'd4; rr2_in = 5'd5;
    mem_valid = 1'b1; mem_wr = 5'd20; mem_data = 32'h120;
    alu_valid = 1'b1; alu_wr = 5'd4; alu_data = 32'h44;
    tick();
    mem_wr = 5'd21; mem_data = 32'h121;
    alu_wr = 5'd5; alu_data = 32'h55;
    tick();
    idle();
    check_wb("rstmid.pre", 1'b1, 5'd21, 32'h121);
    check("rstmid.pre.ready", alu_ready, 0);
    check("rstmid.pre.haz1", hazard1, 1);
    check("rstmid.pre.haz2", hazard2, 1);
    #2 reset = 1'b0;
    #1;
    check_wb("rstmid.async", 1'b0, 5'd0, 32'h0);
    check("rstmid.async.haz1", hazard1, 0);
    check("rstmid.async.haz2", hazard2, 0);
    check("rstmid.async.ready", alu_ready, 1);
    tick();
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rstmid.after_c%0d.regwrite", c), regwrite, 0);
      check($sformatf("rstmid.after_c%0d.haz1", c), hazard1, 0);
    end
    rr1_in = '0; rr2_in = '0;

    // Counter saturation on the CNTW=4 instance
    mem_valid = 1'b1; mem_wr = 5'd22; mem_data = 32'h122;
    alu_valid = 1'b1; alu_wr = 5'd7; alu_data = 32'h77;
    repeat (22) tick();
    check("sat.stall16", stall_count, 20);
    check("sat.stall4", s_stall_count, 15);
    check("sat.ready", alu_ready, 0);
    idle();
    tick();
    check_wb("sat.drain1", 1'b1, 5'd7, 32'h77);
    tick();
    check_wb("sat.drain2", 1'b1, 5'd7, 32'h77);
    tick();
    check("sat.drain3.regwrite", regwrite, 0);
    check("sat.drain3.ready", alu_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
